// File: rtl/cnn_pkg.sv
// Shared constants and types for the conv-lane datapath blocks.
package cnn_pkg;
    localparam int DATA_W = 14;
    localparam int ADDR_W = 14;
    localparam int MAX_W  = 112;
    localparam int MAX_H  = 112;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
endpackage

// File: rtl/pad_coord_counter.sv
// Raster walk over the zero-padded frame; flags interior pixels and the final coordinate.
module pad_coord_counter #(
    parameter int MAX_W = 112,
    parameter int MAX_H = 112,
    parameter int PAD   = 1,
    localparam int WW   = $clog2(MAX_W + 1),
    localparam int HW   = $clog2(MAX_H + 1),
    localparam int CW   = $clog2(((MAX_W > MAX_H) ? MAX_W : MAX_H) + 2 * PAD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [WW-1:0] img_w,
    input  logic [HW-1:0] img_h,
    output logic          interior,
    output logic          last
);
    logic [CW-1:0] pr, pc, w_last, h_last;

    assign w_last = CW'(img_w) + CW'(2 * PAD) - CW'(1);
    assign h_last = CW'(img_h) + CW'(2 * PAD) - CW'(1);

    // Subtracting PAD wraps border rows/cols far above any legal size,
    // so one unsigned compare covers both edges.
    assign interior = ((pr - CW'(PAD)) < CW'(img_h)) && ((pc - CW'(PAD)) < CW'(img_w));
    assign last     = (pr == h_last) && (pc == w_last);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pr <= '0;
            pc <= '0;
        end else if (en) begin
            if (pc == w_last) begin
                pc <= '0;
                pr <= pr + CW'(1);
            end else begin
                pc <= pc + CW'(1);
            end
        end
    end
endmodule

// File: rtl/fmap_pixel_streamer.sv
// Streams one feature-map channel from SRAM as a zero-padded raster into the line-buffer FIFO.
module fmap_pixel_streamer #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int MAX_W  = cnn_pkg::MAX_W,
    parameter int MAX_H  = cnn_pkg::MAX_H,
    parameter int PAD    = 1,
    parameter int ADDR_W = cnn_pkg::ADDR_W,
    localparam int WW    = $clog2(MAX_W + 1),
    localparam int HW    = $clog2(MAX_H + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [WW-1:0]     img_w,
    input  logic [HW-1:0]     img_h,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              out_ready,
    output logic [DATA_W-1:0] input_pixel,
    output logic              wr_en,
    output logic              busy,
    output logic              done
);
    import cnn_pkg::*;

    state_t            state, state_nx;
    logic [WW-1:0]     w_q;
    logic [HW-1:0]     h_q;
    logic [ADDR_W-1:0] ptr;
    logic              s1_vld, s1_pad;
    logic              interior, last, issue, accept;

    assign accept  = (state == IDLE) && start;
    assign issue   = (state == STREAM) && out_ready;
    assign rd_en   = issue && interior;
    assign rd_addr = ptr;
    assign busy    = (state != IDLE);

    pad_coord_counter #(.MAX_W(MAX_W), .MAX_H(MAX_H), .PAD(PAD)) u_coord (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .en       (issue),
        .img_w    (w_q),
        .img_h    (h_q),
        .interior (interior),
        .last     (last)
    );

    // DRAIN ends once s1 is empty and the output register has handed off its last pixel.
    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            IDLE:    if (start) state_nx = STREAM;
            STREAM:  if (issue && last) state_nx = DRAIN;
            DRAIN: begin
                if (!s1_vld && !wr_en) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            w_q         <= '0;
            h_q         <= '0;
            ptr         <= '0;
            s1_vld      <= 1'b0;
            s1_pad      <= 1'b0;
            wr_en       <= 1'b0;
            input_pixel <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                w_q <= img_w;
                h_q <= img_h;
                ptr <= base_addr;
            end else if (rd_en) begin
                ptr <= ptr + ADDR_W'(1);
            end
            // out_ready gates the whole pipe; SRAM holds rd_data while stalled.
            if (out_ready) begin
                s1_vld      <= issue;
                s1_pad      <= issue && !interior;
                wr_en       <= s1_vld;
                input_pixel <= (s1_vld && !s1_pad) ? rd_data : '0;
            end
        end
    end
endmodule

// File: tb/tb_fmap_pixel_streamer.sv
// Randomized bench: PAD=1 and PAD=0 streamers share stimulus, checked against a padded-raster model.
module tb_fmap_pixel_streamer;
    localparam int DATA_W = 14;
    localparam int ADDR_W = 14;
    localparam int MAX_W  = 112;
    localparam int MAX_H  = 112;
    localparam int WW     = $clog2(MAX_W + 1);
    localparam int HW     = $clog2(MAX_H + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start, out_ready;
    logic [ADDR_W-1:0] base_addr;
    logic [WW-1:0]     img_w;
    logic [HW-1:0]     img_h;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int checks = 0, failures = 0;
    int mode = 0, stall_left = 0;
    bit stalled = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: pixel at padded (r,c) is zero on the border, else image pixel (r-p, c-p).
    function automatic logic [DATA_W-1:0] exp_pix(input int p, input int base, input int w,
                                                   input int h, input int r, input int c);
        if (r < p || r >= h + p || c < p || c >= w + p) return '0;
        return mem[(base + (r - p) * w + (c - p)) % (1 << ADDR_W)];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int P = 1 - g;
        logic              rd_en, wr_en, busy, done;
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_data, input_pixel;
        logic [DATA_W-1:0] pix_q[$];
        logic [ADDR_W-1:0] addr_q[$];
        int xfer_cnt = 0, done_cnt = 0;

        fmap_pixel_streamer #(.DATA_W(DATA_W), .MAX_W(MAX_W), .MAX_H(MAX_H),
                              .PAD(P), .ADDR_W(ADDR_W)) u_dut (
            .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
            .img_w(img_w), .img_h(img_h), .rd_en(rd_en), .rd_addr(rd_addr),
            .rd_data(rd_data), .out_ready(out_ready), .input_pixel(input_pixel),
            .wr_en(wr_en), .busy(busy), .done(done)
        );

        always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

        initial begin
            bit hold, pdone;
            logic [DATA_W-1:0] hpix;
            hold = 0; pdone = 0; hpix = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    hold = 0; pdone = 0;
                end else begin
                    if (!out_ready) chk($sformatf("p%0d_rd_en_stall", P), rd_en, 0);
                    if (hold) begin
                        chk($sformatf("p%0d_hold_wr", P), wr_en, 1);
                        chk($sformatf("p%0d_hold_pix", P), input_pixel, hpix);
                    end
                    hold = wr_en && !out_ready;
                    hpix = input_pixel;
                    if (rd_en) begin
                        if (addr_q.size() == 0) chk($sformatf("p%0d_addr_extra", P), 1, 0);
                        else chk($sformatf("p%0d_rd_addr", P), rd_addr, addr_q.pop_front());
                    end
                    if (wr_en) chk($sformatf("p%0d_wr_busy", P), busy, 1);
                    if (wr_en && out_ready) begin
                        xfer_cnt++;
                        if (pix_q.size() == 0) chk($sformatf("p%0d_pix_extra", P), 1, 0);
                        else chk($sformatf("p%0d_pixel", P), input_pixel, pix_q.pop_front());
                    end
                    if (pdone) chk($sformatf("p%0d_busy_after_done", P), busy, 0);
                    if (done) begin
                        done_cnt++;
                        chk($sformatf("p%0d_busy_in_done", P), busy, 1);
                    end
                    pdone = done;
                end
            end
        end
    end

    // out_ready: mode 0 always ready, 1 random, 2 a 4-cycle stall once 7 pixels have gone.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                1: out_ready = ($urandom_range(0, 9) < 7);
                2: begin
                    if (stall_left > 0) begin
                        stall_left--;
                        out_ready = 1'b0;
                    end else if (!stalled && g_dut[0].xfer_cnt == 7) begin
                        stalled    = 1;
                        stall_left = 3;
                        out_ready  = 1'b0;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic run_frame(input int base, input int w, input int h, input int m,
                             input bit mid_start, input int rst_at);
        int k, bound;
        mode = m; stalled = 0; stall_left = 0;
        for (int r = 0; r < h + 2; r++)
            for (int c = 0; c < w + 2; c++) g_dut[0].pix_q.push_back(exp_pix(1, base, w, h, r, c));
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) g_dut[1].pix_q.push_back(exp_pix(0, base, w, h, r, c));
        for (int i = 0; i < w * h; i++) begin
            g_dut[0].addr_q.push_back(ADDR_W'(base + i));
            g_dut[1].addr_q.push_back(ADDR_W'(base + i));
        end
        g_dut[0].xfer_cnt = 0; g_dut[0].done_cnt = 0;
        g_dut[1].xfer_cnt = 0; g_dut[1].done_cnt = 0;

        @(posedge clk); #1;
        start = 1'b1; base_addr = ADDR_W'(base); img_w = WW'(w); img_h = HW'(h);
        @(posedge clk); #1;
        start = 1'b0;
        if (m == 0 && rst_at < 0) begin
            @(negedge clk);
            chk("busy_start", g_dut[0].busy, 1);
            k = 1;
            while (!g_dut[0].wr_en && k < 10) begin
                @(negedge clk);
                k++;
            end
            chk("latency", k, 3);
        end
        if (mid_start) begin
            repeat (2) @(posedge clk);
            #1;
            start = 1'b1; base_addr = ADDR_W'($urandom); img_w = WW'(7); img_h = HW'(5);
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (rst_at >= 0) begin
            k = 0;
            while (g_dut[0].xfer_cnt < rst_at && k < 2000) begin
                @(posedge clk);
                k++;
            end
            chk("rst_reach", k < 2000, 1);
            #1 rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            for (int i = 0; i < 2; i++) begin
                chk("rst_wr_en", (i == 0) ? g_dut[0].wr_en : g_dut[1].wr_en, 0);
                chk("rst_busy", (i == 0) ? g_dut[0].busy : g_dut[1].busy, 0);
            end
            chk("rst_no_done", g_dut[0].done_cnt, 0);
        end else begin
            k = 0;
            bound = 6 * (w + 2) * (h + 2) + 100;
            while ((g_dut[0].done_cnt == 0 || g_dut[1].done_cnt == 0) && k < bound) begin
                @(posedge clk);
                k++;
            end
            chk("timeout", k < bound, 1);
            repeat (3) @(posedge clk);
            chk("p1_count", g_dut[0].xfer_cnt, (w + 2) * (h + 2));
            chk("p0_count", g_dut[1].xfer_cnt, w * h);
            chk("p1_done_cnt", g_dut[0].done_cnt, 1);
            chk("p0_done_cnt", g_dut[1].done_cnt, 1);
            chk("p1_pix_left", g_dut[0].pix_q.size(), 0);
            chk("p0_addr_left", g_dut[1].addr_q.size(), 0);
        end
        g_dut[0].pix_q.delete(); g_dut[0].addr_q.delete();
        g_dut[1].pix_q.delete(); g_dut[1].addr_q.delete();
    endtask

    initial begin
        int w, h, b;
        rst = 1'b1; start = 1'b0; base_addr = '0; img_w = '0; img_h = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
        for (int i = 0; i < 9; i++) mem[20 + i] = DATA_W'(i + 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en0", g_dut[0].wr_en, 0);
        chk("rst_busy0", g_dut[0].busy, 0);
        chk("rst_done0", g_dut[0].done, 0);
        chk("rst_rd_en0", g_dut[0].rd_en, 0);
        chk("rst_pix0", g_dut[0].input_pixel, 0);
        chk("rst_addr0", g_dut[0].rd_addr, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        run_frame(20, 3, 3, 0, 0, -1);
        run_frame(20, 3, 3, 2, 0, -1);
        run_frame(100, 4, 2, 0, 0, -1);
        run_frame(20, 3, 3, 0, 1, -1);
        run_frame(20, 3, 3, 0, 0, 12);
        run_frame(20, 3, 3, 0, 0, -1);
        run_frame(300, 1, 1, 1, 0, -1);
        run_frame(400, 1, 6, 1, 0, -1);
        run_frame(500, 6, 1, 1, 0, -1);
        for (int n = 0; n < 8; n++) begin
            w = $urandom_range(1, 12);
            h = $urandom_range(1, 12);
            b = $urandom_range(0, (1 << ADDR_W) - w * h);
            run_frame(b, w, h, 1, 0, -1);
        end
        run_frame(0, MAX_W, MAX_H, 0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
